// File: rtl/alu4_pkg.sv
// Opcode encodings shared by the ALU core and the integration code around it.
package alu4_pkg;

  localparam logic [3:0] OP_ADC  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SBC  = 4'b1111;

  // True for the four opcodes that drive the ripple adder chain.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu4_core_fa_cell.sv
// Single-bit full adder; one instance per bit of the ALU ripple chain.
import alu4_pkg::*;

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/alu4_core.sv
// Registered WIDTH-bit ALU: ADD/ADC/SUB/SBC on a ripple-carry chain, NAND/OR/XOR/NOT,
// 1-bit logical right shift, with carry and signed-overflow flags.
// Optional: define ALU_ZERO_FLAG_EN to add a registered zero flag output zf.
import alu4_pkg::*;

module alu4_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] aluin_a,
  input  logic [WIDTH-1:0] aluin_b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] alu_out,
  output logic             cout,
  output logic             of,
  output logic             out_valid
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic             zf
`endif
);

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] res_d,  res_q;
  logic             cout_d, cout_q;
  logic             of_d,   of_q;
  logic             vld_q;

  // B inversion and carry-in select feeding the shared adder chain
  always_comb begin
    b_eff = aluin_b;
    c0    = 1'b0;
    unique case (opcode)
      OP_ADC:  c0 = cin;
      OP_SUB:  begin b_eff = ~aluin_b; c0 = 1'b1; end
      OP_SBC:  begin b_eff = ~aluin_b; c0 = cin;  end
      default: ;
    endcase
  end

  assign carry[0] = c0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_fa (
      .a  (aluin_a[i]),
      .b  (b_eff[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Result and flag select; unknown opcodes produce all zeros
  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    of_d   = 1'b0;
    if (is_arith(opcode)) begin
      res_d  = sum;
      cout_d = carry[WIDTH];
      of_d   = carry[WIDTH] ^ carry[WIDTH-1];
    end else begin
      unique case (opcode)
        OP_NAND: res_d = ~(aluin_a & aluin_b);
        OP_OR:   res_d = aluin_a | aluin_b;
        OP_XOR:  res_d = aluin_a ^ aluin_b;
        OP_NOT:  res_d = ~aluin_a;
        OP_SHR:  begin
          res_d  = {1'b0, aluin_a[WIDTH-1:1]};
          cout_d = aluin_a[0];
        end
        default: ;
      endcase
    end
  end

  // Output register stage: load on in_valid, hold otherwise; out_valid pulses per load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        res_q  <= res_d;
        cout_q <= cout_d;
        of_q   <= of_d;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic zf_q;

  // Zero flag registered alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zf_q <= 1'b0;
    else if (in_valid) zf_q <= (res_d == '0);
  end

  assign zf = zf_q;
`endif

  assign alu_out   = res_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu4_core.sv
// Directed testbench for alu4_core (WIDTH=4) with hand-computed expected values.
module tb_alu4_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] aluin_a = '0;
  logic [3:0] aluin_b = '0;
  logic [3:0] opcode = '0;
  logic       cin = 1'b0;
  logic [3:0] alu_out;
  logic       cout;
  logic       of;
  logic       out_valid;
`ifdef ALU_ZERO_FLAG_EN
  logic       zf;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu4_core #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .aluin_a   (aluin_a),
    .aluin_b   (aluin_b),
    .opcode    (opcode),
    .cin       (cin),
    .alu_out   (alu_out),
    .cout      (cout),
    .of        (of),
    .out_valid (out_valid)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zf        (zf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] e_res, input logic e_c,
                     input logic e_of, input logic e_vld);
    n_vec++;
    assert (alu_out === e_res) else begin
      n_err++;
      $error("FAIL %s alu_out: got %b expected %b", tag, alu_out, e_res);
    end
    n_vec++;
    assert (cout === e_c) else begin
      n_err++;
      $error("FAIL %s cout: got %b expected %b", tag, cout, e_c);
    end
    n_vec++;
    assert (of === e_of) else begin
      n_err++;
      $error("FAIL %s of: got %b expected %b", tag, of, e_of);
    end
    n_vec++;
    assert (out_valid === e_vld) else begin
      n_err++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, e_vld);
    end
  endtask

`ifdef ALU_ZERO_FLAG_EN
  task automatic chk_zf(input string tag, input logic e_zf);
    n_vec++;
    assert (zf === e_zf) else begin
      n_err++;
      $error("FAIL %s zf: got %b expected %b", tag, zf, e_zf);
    end
  endtask
`endif

  // One op: present at negedge, capture at posedge, sample 1 time unit later.
  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] opc,
                    input logic c);
    @(negedge clk);
    aluin_a  = a;
    aluin_b  = b;
    opcode   = opc;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held low with clock running
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op(4'b0011, 4'b0011, 4'b0010, 1'b1); chk("ADD", 4'b0110, 1'b0, 1'b0, 1'b1);
    op(4'b0110, 4'b0101, 4'b0001, 1'b1); chk("ADC", 4'b1100, 1'b0, 1'b1, 1'b1);
    op(4'b0111, 4'b0110, 4'b0011, 1'b0); chk("SUB", 4'b0001, 1'b1, 1'b0, 1'b1);
    op(4'b0100, 4'b0011, 4'b1111, 1'b0); chk("SBC", 4'b0000, 1'b1, 1'b0, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
    chk_zf("SBC", 1'b1);
`endif
    op(4'b0100, 4'b0011, 4'b1111, 1'b1); chk("SBC_cin1", 4'b0001, 1'b1, 1'b0, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
    chk_zf("SBC_cin1", 1'b0);
`endif
    op(4'b0111, 4'b0001, 4'b0010, 1'b0); chk("ADD_posovf", 4'b1000, 1'b0, 1'b1, 1'b1);
    op(4'b1111, 4'b0001, 4'b0010, 1'b0); chk("ADD_wrap", 4'b0000, 1'b1, 1'b0, 1'b1);
    op(4'b0011, 4'b0101, 4'b0011, 1'b1); chk("SUB_borrow", 4'b1110, 1'b0, 1'b0, 1'b1);
    op(4'b1000, 4'b0001, 4'b0011, 1'b0); chk("SUB_negovf", 4'b0111, 1'b1, 1'b1, 1'b1);
    op(4'b0111, 4'b1010, 4'b0100, 1'b1); chk("NAND", 4'b1101, 1'b0, 1'b0, 1'b1);
    op(4'b0111, 4'b0011, 4'b0101, 1'b0); chk("OR", 4'b0111, 1'b0, 1'b0, 1'b1);
    op(4'b0101, 4'b1110, 4'b0110, 1'b0); chk("XOR", 4'b1011, 1'b0, 1'b0, 1'b1);
    op(4'b1011, 4'b1111, 4'b0111, 1'b0); chk("NOT", 4'b0100, 1'b0, 1'b0, 1'b1);
    op(4'b0101, 4'b0000, 4'b1000, 1'b0); chk("SHR", 4'b0010, 1'b1, 1'b0, 1'b1);
    op(4'b1111, 4'b1111, 4'b0000, 1'b1); chk("undef_op", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Hold: load a value, then idle one edge with changing inputs
    op(4'b1001, 4'b0000, 4'b1000, 1'b0); chk("SHR_odd", 4'b0100, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    aluin_a = 4'b0000;
    opcode  = 4'b0010;
    @(posedge clk);
    #1;
    chk("hold", 4'b0100, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges clears outputs immediately
    op(4'b0110, 4'b0101, 4'b0001, 1'b1); chk("ADC_pre_rst", 4'b1100, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Pending op presented while reset is low is dropped
    @(negedge clk);
    aluin_a  = 4'b0011;
    aluin_b  = 4'b0011;
    opcode   = 4'b0010;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("drop_in_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    op(4'b0011, 4'b0011, 4'b0010, 1'b0); chk("ADD_after_rst", 4'b0110, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
